// File: rtl/user_cmd_conditioner_pkg.sv
// Shared types and default timing for the user command conditioner.
// Optional pending-command capture is enabled with CMD_PENDING_EN.
package user_cmd_conditioner_pkg;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'b00,
    CMD_STRAIGHT = 2'b01,
    CMD_LEFT     = 2'b10,
    CMD_RIGHT    = 2'b11
  } cmd_code_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 2_000_000;
  localparam int LOCKOUT_CYCLES_DEF  = 10_000_000;

  // Fixed priority: straight wins over left wins over right.
  function automatic cmd_code_t resolve_cmd(
    input logic s,
    input logic l,
    input logic r
  );
    if (s)      return CMD_STRAIGHT;
    else if (l) return CMD_LEFT;
    else if (r) return CMD_RIGHT;
    else        return CMD_NONE;
  endfunction

endpackage

// File: rtl/user_cmd_conditioner_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce
  import user_cmd_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    prev_d  = level_q;
    press_d = level_q & ~prev_q;
    // Any sample agreeing with the level restarts the count.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/user_cmd_conditioner.sv
// Debounces three direction buttons and issues rate-limited command pulses.
// Define CMD_PENDING_EN to hold one command arriving during lockout.
module user_cmd_conditioner
  import user_cmd_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_straight,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       go_straight_command,
  output logic       turn_left_command,
  output logic       turn_right_command,
  output logic [1:0] last_cmd,
  output logic       lockout_active
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  logic      press_s, press_l, press_r;
  cmd_code_t evt, issue;
  cmd_code_t pulse_q, pulse_d;
  cmd_code_t last_q, last_d;
  state_t    state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
`ifdef CMD_PENDING_EN
  cmd_code_t pend_q, pend_d;
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_s (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_straight), .press_o(press_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_left), .press_o(press_l)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_right), .press_o(press_r)
  );

  assign evt = resolve_cmd(press_s, press_l, press_r);

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    last_d  = last_q;
    pulse_d = CMD_NONE;
    issue   = evt;
`ifdef CMD_PENDING_EN
    pend_d  = pend_q;
    // A held command is older than anything arriving now.
    if (pend_q != CMD_NONE) issue = pend_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (issue != CMD_NONE) begin
          pulse_d = issue;
          last_d  = issue;
          lock_d  = LW'(LOCKOUT_CYCLES);
          state_d = ST_LOCKOUT;
`ifdef CMD_PENDING_EN
          pend_d  = CMD_NONE;
`endif
        end
      end
      ST_LOCKOUT: begin
        lock_d = lock_q - 1'b1;
        if (lock_q == LW'(1)) state_d = ST_IDLE;
`ifdef CMD_PENDING_EN
        if (pend_q == CMD_NONE) pend_d = evt;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      last_q  <= CMD_NONE;
      pulse_q <= CMD_NONE;
`ifdef CMD_PENDING_EN
      pend_q  <= CMD_NONE;
`endif
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      pulse_q <= pulse_d;
`ifdef CMD_PENDING_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign go_straight_command = (pulse_q == CMD_STRAIGHT);
  assign turn_left_command   = (pulse_q == CMD_LEFT);
  assign turn_right_command  = (pulse_q == CMD_RIGHT);
  assign last_cmd            = last_q;
  assign lockout_active      = (lock_q != '0);

endmodule

// File: tb/tb_user_cmd_conditioner.sv
// Scoreboard bench for user_cmd_conditioner with short debounce/lockout.
// Honours CMD_PENDING_EN to select the expected lockout behaviour.
module tb_user_cmd_conditioner;

  localparam int DB = 4;
  localparam int LO = 8;
  localparam int LAT = DB + 3;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_straight = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic go_straight_command;
  logic turn_left_command;
  logic turn_right_command;
  logic [1:0] last_cmd;
  logic lockout_active;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [1:0] exp_last = 2'b00;
  int   lo = 0;

  user_cmd_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .LOCKOUT_CYCLES(LO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_straight(btn_straight),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .go_straight_command(go_straight_command),
    .turn_left_command(turn_left_command),
    .turn_right_command(turn_right_command),
    .last_cmd(last_cmd),
    .lockout_active(lockout_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  // Output monitor: pops the scoreboard on every observed pulse.
  always @(negedge clk) begin
    int   np;
    logic [1:0] code;
    exp_t e;
    if (!rst_seen) begin
      n_chk++;
      if ({go_straight_command, turn_left_command, turn_right_command,
           last_cmd, lockout_active} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got g=%b l=%b r=%b last=%b lo=%b want all 0",
                 cyc, go_straight_command, turn_left_command,
                 turn_right_command, last_cmd, lockout_active);
      end
      exp_last = 2'b00;
      lo = 0;
    end else begin
      np = int'(go_straight_command) + int'(turn_left_command)
         + int'(turn_right_command);
      if (np > 1) begin
        n_chk++;
        n_fail++;
        $display("FAIL onehot cyc=%0d got %0d pulses want <=1", cyc, np);
      end else if (np == 1) begin
        code = go_straight_command ? 2'b01 :
               turn_left_command   ? 2'b10 : 2'b11;
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse cyc=%0d got code %b want none", cyc, code);
        end else begin
          e = sb.pop_front();
          if (e.code !== code || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL pulse cyc=%0d code=%b want cyc=%0d code=%b",
                     cyc, code, e.cyc, e.code);
          end
          exp_last = e.code;
          lo = LO;
        end
      end
      n_chk++;
      if (last_cmd !== exp_last) begin
        n_fail++;
        $display("FAIL last_cmd cyc=%0d got %b want %b", cyc, last_cmd, exp_last);
      end
      n_chk++;
      if (lockout_active !== (lo != 0)) begin
        n_fail++;
        $display("FAIL lockout_active cyc=%0d got %b want %b",
                 cyc, lockout_active, (lo != 0));
      end
      if (lo != 0) lo--;
    end
  end

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sync_now(output int k);
    @(posedge clk);
    #1;
    k = cyc + 1;
  endtask

  task automatic expect_drained(input string name);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing got %0d pending pulses want 0 (next cyc=%0d)",
               name, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    at_cycle(3);
    n_chk++;
    if ({go_straight_command, turn_left_command, turn_right_command,
         last_cmd, lockout_active} !== 6'b0) begin
      n_fail++;
      $display("FAIL test_reset got %b want 000000",
               {go_straight_command, turn_left_command, turn_right_command,
                last_cmd, lockout_active});
    end
    rst_n = 1'b1;
    at_cycle(6);
  endtask

  task automatic test_glitch();
    int k;
    sync_now(k);
    btn_right = 1'b1;
    at_cycle(k + 2);
    btn_right = 1'b0;
    at_cycle(k + 25);
    n_chk++;
    if (last_cmd !== 2'b00) begin
      n_fail++;
      $display("FAIL glitch_last got %b want 00", last_cmd);
    end
    expect_drained("glitch");
  endtask

  task automatic test_single_left();
    int k;
    sync_now(k);
    btn_left = 1'b1;
    sb.push_back('{2'b10, k + LAT});
    at_cycle(k + 20);
    btn_left = 1'b0;
    at_cycle(k + 40);
    expect_drained("single_left");
  endtask

  task automatic test_simultaneous();
    int k;
    sync_now(k);
    btn_straight = 1'b1;
    btn_right = 1'b1;
    sb.push_back('{2'b01, k + LAT});
    at_cycle(k + 20);
    btn_straight = 1'b0;
    btn_right = 1'b0;
    at_cycle(k + 40);
    n_chk++;
    if (last_cmd !== 2'b01) begin
      n_fail++;
      $display("FAIL simultaneous_last got %b want 01", last_cmd);
    end
    expect_drained("simultaneous");
  endtask

  task automatic test_lockout_event();
    int k;
    logic [1:0] want;
    sync_now(k);
    btn_left = 1'b1;
    sb.push_back('{2'b10, k + LAT});
    at_cycle(k + 4);
    btn_right = 1'b1;
    at_cycle(k + 7);
    btn_left = 1'b0;
`ifdef CMD_PENDING_EN
    sb.push_back('{2'b11, k + LAT + LO + 1});
    want = 2'b11;
`else
    want = 2'b10;
`endif
    at_cycle(k + 40);
    btn_right = 1'b0;
    at_cycle(k + 60);
    n_chk++;
    if (last_cmd !== want) begin
      n_fail++;
      $display("FAIL lockout_event_last got %b want %b", last_cmd, want);
    end
    expect_drained("lockout_event");
  endtask

  task automatic test_reset_mid_lockout();
    int k;
    sync_now(k);
    btn_left = 1'b1;
    sb.push_back('{2'b10, k + LAT});
    at_cycle(k + 8);
    rst_n = 1'b0;
    at_cycle(k + 9);
    rst_n = 1'b1;
    n_chk++;
    if ({last_cmd, lockout_active, turn_left_command} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid got last=%b lo=%b left=%b want 0",
               last_cmd, lockout_active, turn_left_command);
    end
    sb.push_back('{2'b10, k + 10 + LAT});
    at_cycle(k + 30);
    btn_left = 1'b0;
    at_cycle(k + 50);
    expect_drained("reset_mid");
  endtask

  task automatic test_hold();
    int k;
    sync_now(k);
    btn_straight = 1'b1;
    sb.push_back('{2'b01, k + LAT});
    at_cycle(k + 100);
    btn_straight = 1'b0;
    at_cycle(k + 130);
    expect_drained("hold");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_left();
    test_simultaneous();
    test_lockout_event();
    test_reset_mid_lockout();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/user_cmd_conditioner.md
USER_CMD_CONDITIONER -- requirements
Module: user_cmd_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 2_000_000, consecutive stable synchronized samples required to accept a button level change (20 ms @ 100 MHz); legal range >= 1.
REQ-002 Parameter: LOCKOUT_CYCLES, 10_000_000, cycles after an issued command during which new commands are not issued; legal range >= 1.
REQ-003 Port: clk  input  1  system clock, single clock domain.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: btn_straight  input  1  raw asynchronous go-straight button.
REQ-006 Port: btn_left  input  1  raw asynchronous turn-left button.
REQ-007 Port: btn_right  input  1  raw asynchronous turn-right button.
REQ-008 Port: go_straight_command  output  1  single-cycle command pulse to the semi-auto driving stage.
REQ-009 Port: turn_left_command  output  1  single-cycle command pulse.
REQ-010 Port: turn_right_command  output  1  single-cycle command pulse.
REQ-011 Port: last_cmd  output  2  code of most recently issued command: 00 none, 01 straight, 10 left, 11 right.
REQ-012 Port: lockout_active  output  1  high while the lockout counter is non-zero.

Function
REQ-013 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Debounced level SHALL flip only after the synchronized sample differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears the per-button counter.
REQ-015 A press event SHALL be a 0->1 transition of the debounced level; releases generate nothing.
REQ-016 Latency: raw button rising and then stable from clock edge k SHALL produce the command pulse high during cycle k+DEBOUNCE_CYCLES+3, given no lockout.
REQ-017 At most one command output SHALL be high in any cycle; each pulse lasts exactly one cycle.
REQ-018 Simultaneous press events SHALL be resolved by fixed priority straight > left > right; losers are discarded.
REQ-019 State machine IDLE/LOCKOUT: IDLE + event -> issue pulse, load counter with LOCKOUT_CYCLES, go LOCKOUT; LOCKOUT decrements each cycle, returns to IDLE in the cycle after counter reaches 1.
REQ-020 Events arriving in LOCKOUT SHALL be discarded (see REQ-025 for the macro variant).
REQ-021 last_cmd SHALL update in the same cycle as the pulse and hold until the next issued command.
REQ-022 A button held continuously SHALL produce exactly one command regardless of hold duration.

Reset
REQ-023 With rst_n low at a clock edge: all command outputs 0, last_cmd 00, lockout_active 0, FSM IDLE, all counters 0, synchronizer and debounced levels 0.
REQ-024 Reset mid-lockout or mid-debounce SHALL abort it; a button still held after reset SHALL be re-debounced and issue one command.

Configuration
REQ-025 Macro CMD_PENDING_EN: when defined, a one-deep pending register SHALL capture the first (priority-resolved) event in LOCKOUT, later events dropped, and issue it in the first IDLE cycle, reloading lockout; when undefined, no pending register exists and REQ-020 applies.

Structure
REQ-026 Shared package SHALL hold the cmd_code typedef (2-bit, four codes of REQ-011), FSM state typedef, and default values of both parameters.
REQ-027 One sub-module btn_debounce (synchronizer + counter + edge detect) SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
REQ-028 btn_left high from edge 10 -> turn_left_command high only in cycle 17, last_cmd=10, lockout_active high cycles 17-24.
REQ-029 btn_right glitch high 3 cycles then low -> no command, last_cmd stays 00.
REQ-030 btn_straight and btn_right rise same edge -> only go_straight_command pulses, last_cmd=01.
REQ-031 btn_left pressed, released, btn_right pressed 4 cycles into lockout -> undefined macro: no right pulse; CMD_PENDING_EN: right pulse in first IDLE cycle, last_cmd=11.
REQ-032 rst_n low 1 cycle at cycle 3 of lockout with btn_left held -> outputs cleared, one new left pulse 7 cycles after reset release.
REQ-033 btn_straight held 100 cycles -> exactly one go_straight_command pulse.
